// File: rtl/tone_cmd_queue_pkg.sv
// Tone-word field layout shared by the tone command queue, the voice engine
// and the software header generator.
package tone_cmd_queue_pkg;

    localparam int unsigned TONE_W       = 32;
    localparam int unsigned GATE_BIT     = 31;
    localparam int unsigned VOICE_LSB    = 28;
    localparam int unsigned VOICE_FLD_W  = 3;
    localparam int unsigned VEL_LSB      = 24;
    localparam int unsigned VEL_W        = 4;
    localparam int unsigned INC_W        = 24;
    localparam int unsigned OVF_W        = 8;

endpackage

// File: rtl/tone_cmd_queue_if.sv
// Command handshake between the tone queue (master) and the voice engine (slave).
interface tone_cmd_queue_if
    import tone_cmd_queue_pkg::*;
#(
    parameter int unsigned VOICE_W = 3
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_gate;
    logic [VOICE_W-1:0] cmd_voice;
    logic [VEL_W-1:0]   cmd_vel;
    logic [INC_W-1:0]   cmd_inc;

    modport master (
        output cmd_valid, cmd_gate, cmd_voice, cmd_vel, cmd_inc,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_gate, cmd_voice, cmd_vel, cmd_inc,
        output cmd_ready
    );

endinterface

// File: rtl/tone_cmd_queue_fifo_mem.sv
// tone_fifo_mem: synchronous DEPTH x WIDTH FIFO storage. Head data is read
// combinationally from the registered read pointer; the caller guarantees
// no write when full (unless popping) and no read when empty.
module tone_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage array: written at the tail, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (rd_en && !wr_en) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/tone_cmd_queue.sv
// tone_cmd_queue: captures tone words strobed by the CPU PIO into a FIFO and
// presents them one at a time to the voice engine over valid/ready.
// Optional feature: define TONE_QUEUE_OVF_CNT_EN to count dropped words in
// ovf_count (saturating at 255); otherwise ovf_count is tied to zero.
module tone_cmd_queue
    import tone_cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned VOICE_W = 3
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [TONE_W-1:0]  tone_word,
    input  logic               ld_fifo,
    output logic               fifo_full,
    output logic               run,
    output logic [OVF_W-1:0]   ovf_count,
    tone_cmd_queue_if.master   cmd
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic              ld_q;
    logic              ld_rise;
    logic              push;
    logic              pop;
    logic [TONE_W-1:0] head;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              valid_nxt;

    tone_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (TONE_W)
    ) u_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .wr_en   (push),
        .wr_data (tone_word),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count)
    );

    // ld_fifo history for rising-edge detection.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) ld_q <= 1'b0;
        else                ld_q <= ld_fifo;
    end

    // Accept/drop decision and next occupancy for the registered status flags.
    always_comb begin
        ld_rise   = ld_fifo & ~ld_q;
        pop       = (count != '0) & (~cmd.cmd_valid | cmd.cmd_ready);
        push      = ld_rise & ((count < FULL_CNT) | pop);
        valid_nxt = pop | (cmd.cmd_valid & ~cmd.cmd_ready);
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // Output register: reload from the head when empty or when the current command is taken.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_gate  <= 1'b0;
            cmd.cmd_voice <= '0;
            cmd.cmd_vel   <= '0;
            cmd.cmd_inc   <= '0;
        end else if (pop) begin
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_gate  <= head[GATE_BIT];
            cmd.cmd_voice <= head[VOICE_LSB +: VOICE_W];
            cmd.cmd_vel   <= head[VEL_LSB +: VEL_W];
            cmd.cmd_inc   <= head[INC_W-1:0];
        end else if (cmd.cmd_ready) begin
            cmd.cmd_valid <= 1'b0;
        end
    end

    // Status flags registered from next-state values so they track the FIFO cycle-accurately.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            fifo_full <= 1'b0;
            run       <= 1'b0;
        end else begin
            fifo_full <= (count_nxt == FULL_CNT);
            run       <= (count_nxt != '0) | valid_nxt;
        end
    end

`ifdef TONE_QUEUE_OVF_CNT_EN
    logic              drop;
    logic [OVF_W-1:0]  ovf_q;

    assign drop = ld_rise & ~push;

    // Saturating count of words dropped because the queue was full.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ovf_q <= '0;
        end else if (drop && (ovf_q != '1)) begin
            ovf_q <= ovf_q + 1'b1;
        end
    end

    assign ovf_count = ovf_q;
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_tone_cmd_queue.sv
// Self-checking bench for tone_cmd_queue: table-driven single-load vectors plus
// hand-written multi-cycle sequences. A negedge monitor scoreboards every
// accepted command and checks stability under backpressure.
module tb_tone_cmd_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tone_word;
    logic        ld_fifo;
    logic        fifo_full;
    logic        run;
    logic [7:0]  ovf_count;

    tone_cmd_queue_if #(.VOICE_W(3)) cmd_if();

    tone_cmd_queue #(
        .DEPTH   (16),
        .VOICE_W (3)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .tone_word     (tone_word),
        .ld_fifo       (ld_fifo),
        .fifo_full     (fifo_full),
        .run           (run),
        .ovf_count     (ovf_count),
        .cmd           (cmd_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] w);
        tone_word = w;
        ld_fifo   = 1'b1;
        tick();
        ld_fifo   = 1'b0;
        tick();
    endtask

    // Scoreboard and backpressure monitor.
    logic [31:0] cur;
    logic [31:0] exp_q[$];
    int          n_rcv = 0;
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word = '0;

    assign cur = {cmd_if.cmd_gate, cmd_if.cmd_voice, cmd_if.cmd_vel, cmd_if.cmd_inc};

    always @(negedge clk) begin
        if (mon_en && rst_n === 1'b1) begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
                chk("stall_data", cur, prev_word);
            end
            if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                n_rcv++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: got 0x%0h expected none at %0t", cur, $time);
                end else begin
                    chk("cmd_order", cur, exp_q.pop_front());
                end
            end
            prev_stall = cmd_if.cmd_valid & ~cmd_if.cmd_ready;
            prev_word  = cur;
        end else begin
            prev_stall = 1'b0;
        end
    end

    typedef struct {
        logic [31:0] word;
        logic        gate;
        logic [2:0]  voice;
        logic [3:0]  vel;
        logic [23:0] inc;
    } vec_t;

    vec_t        vt[4];
    int          n0;
    int          cyc;
    logic [7:0]  exp_ovf;
    logic [31:0] w;

    initial begin
        vt[0] = '{32'h9A00_1234, 1'b1, 3'd1, 4'hA, 24'h001234};
        vt[1] = '{32'h7FAB_CDEF, 1'b0, 3'd7, 4'hF, 24'hABCDEF};
        vt[2] = '{32'hE500_0001, 1'b1, 3'd6, 4'h5, 24'h000001};
        vt[3] = '{32'h00FF_FFFF, 1'b0, 3'd0, 4'h0, 24'hFFFFFF};

        rst_n           = 1'b0;
        ld_fifo         = 1'b0;
        tone_word       = '0;
        cmd_if.cmd_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);
        chk("rst_full",  {31'd0, fifo_full}, 32'd0);
        chk("rst_run",   {31'd0, run}, 32'd0);
        chk("rst_ovf",   {24'd0, ovf_count}, 32'd0);
        chk("rst_fields", cur, 32'd0);
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Single loads: latency N+2, one-cycle valid, field decode
        for (int i = 0; i < 4; i++) begin
            cmd_if.cmd_ready = 1'b1;
            tone_word = vt[i].word;
            ld_fifo   = 1'b1;
            exp_q.push_back(vt[i].word);
            @(negedge clk);
            chk("t1_valid_N", {31'd0, cmd_if.cmd_valid}, 32'd0);
            tick();
            ld_fifo = 1'b0;
            @(negedge clk);
            chk("t1_valid_N1", {31'd0, cmd_if.cmd_valid}, 32'd0);
            chk("t1_run_N1", {31'd0, run}, 32'd1);
            tick();
            @(negedge clk);
            chk("t1_valid_N2", {31'd0, cmd_if.cmd_valid}, 32'd1);
            chk("t1_gate",  {31'd0, cmd_if.cmd_gate}, {31'd0, vt[i].gate});
            chk("t1_voice", {29'd0, cmd_if.cmd_voice}, {29'd0, vt[i].voice});
            chk("t1_vel",   {28'd0, cmd_if.cmd_vel}, {28'd0, vt[i].vel});
            chk("t1_inc",   {8'd0, cmd_if.cmd_inc}, {8'd0, vt[i].inc});
            chk("t1_run_N2", {31'd0, run}, 32'd1);
            tick();
            @(negedge clk);
            chk("t1_valid_N3", {31'd0, cmd_if.cmd_valid}, 32'd0);
            chk("t1_run_N3", {31'd0, run}, 32'd0);
            tick();
        end

        // Held level loads exactly one word
        n0 = n_rcv;
        tone_word = 32'h3123_4567;
        ld_fifo   = 1'b1;
        exp_q.push_back(32'h3123_4567);
        repeat (10) tick();
        ld_fifo = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("t2_cmd_count", n_rcv - n0, 32'd1);
        chk("t2_run", {31'd0, run}, 32'd0);
        tick();

        // Stall and fill: 17 accepted, 3 dropped
        cmd_if.cmd_ready = 1'b0;
        n0 = n_rcv;
        for (int i = 1; i <= 20; i++) begin
            w = 32'hA000_0000 + i;
            if (i <= 17) exp_q.push_back(w);
            pulse(w);
            @(negedge clk);
            chk("t3_full", {31'd0, fifo_full}, (i >= 17) ? 32'd1 : 32'd0);
        end
`ifdef TONE_QUEUE_OVF_CNT_EN
        exp_ovf = 8'd3;
`else
        exp_ovf = 8'd0;
`endif
        chk("t3_ovf", {24'd0, ovf_count}, {24'd0, exp_ovf});
        chk("t3_run", {31'd0, run}, 32'd1);
        chk("t3_head", cur, 32'hA000_0001);

        // Full with simultaneous pop and load, then drain in order
        tick();
        cmd_if.cmd_ready = 1'b1;
        tone_word = 32'hC5A5_5A5A;
        ld_fifo   = 1'b1;
        exp_q.push_back(32'hC5A5_5A5A);
        cyc = 0;
        while (cyc < 60) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk("t4_full_kept", {31'd0, fifo_full}, 32'd1);
                chk("t4_ovf_kept", {24'd0, ovf_count}, {24'd0, exp_ovf});
            end
            if (cyc > 1 && !run && !cmd_if.cmd_valid) break;
            tick();
            ld_fifo = 1'b0;
            cyc++;
        end
        chk("t3_drain_count", n_rcv - n0, 32'd18);
        chk("t3_drain_left", exp_q.size(), 32'd0);
        chk("t3_run_idle", {31'd0, run}, 32'd0);
        tick();

        // Random backpressure over 100 loads
        n0 = n_rcv;
        for (int i = 0; i < 100; i++) begin
            w = $urandom;
            exp_q.push_back(w);
            tone_word = w;
            ld_fifo   = 1'b1;
            cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
            tick();
            ld_fifo   = 1'b0;
            cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        cmd_if.cmd_ready = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (!run && !cmd_if.cmd_valid) break;
            tick();
            cyc++;
        end
        chk("t5_count", n_rcv - n0, 32'd100);
        chk("t5_left", exp_q.size(), 32'd0);
        chk("t5_ovf", {24'd0, ovf_count}, {24'd0, exp_ovf});
        tick();

        // Reset mid-stream with five words queued
        cmd_if.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = 32'h5000_0000 + i;
            exp_q.push_back(w);
            pulse(w);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);
        chk("t6_full",  {31'd0, fifo_full}, 32'd0);
        chk("t6_run",   {31'd0, run}, 32'd0);
        chk("t6_ovf",   {24'd0, ovf_count}, 32'd0);
        chk("t6_fields", cur, 32'd0);
        exp_q.delete();
        n0 = n_rcv;
        // ld_fifo high across release loads exactly one fresh word
        tone_word = 32'h8F00_AAAA;
        ld_fifo   = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        exp_q.push_back(32'h8F00_AAAA);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        ld_fifo = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("t6_cmd_count", n_rcv - n0, 32'd1);
        chk("t6_left", exp_q.size(), 32'd0);
        chk("t6_idle", {31'd0, run}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
